drift_applicator: RTL and testbench

Consumer end of the drift handshake: takes `pos_drift_ready`/`neg_drift_ready` requests from the drift accumulator and applies each one as a ±1-cycle change to the half-period of a locally generated clock. It returns `drift_accepted` at the moment of application. It sits between the accumulator and the recovered-clock fan-out in the clks_alot clock-recovery path, and also reports the signed net drift applied since reset.

---
 rtl/drift_applicator_pkg.sv | 18 +
 rtl/drift_applicator_sat_signed_counter.sv | 35 +++
 rtl/drift_applicator.sv | 139 +++++++++++++
 tb/tb_drift_applicator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drift_applicator_pkg.sv
// Shared clock-domain bundle and clock-recovery constants for the drift applicator.
package common_p;
   typedef struct packed {
      logic clk;
      logic sync_rst;
   } clk_dom_s;
endpackage

package clks_alot_p;
   localparam int HALF_PERIOD_WIDTH   = 16;
   localparam int DRIFT_COUNTER_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } applicator_state_e;
endpackage

// File: rtl/drift_applicator_sat_signed_counter.sv
// Signed up/down counter that clamps at the two's-complement extremes instead of wrapping.
module sat_signed_counter #(
   parameter int W = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                inc_i,
   input  logic                dec_i,
   output logic signed [W-1:0] count_o
);
   localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]        ONE     = {{(W-1){1'b0}}, 1'b1};

   logic signed [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != MAX_VAL)) begin
         count_d = count_q + ONE;
      end else if (dec_i && !inc_i && (count_q != MIN_VAL)) begin
         count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/drift_applicator.sv
// Generates a local clock from programmable high/low phase lengths and applies +/-1 cycle
// drift requests to the next half-period, reporting acceptance, conflicts and net drift.
module drift_applicator #(
   parameter int HALF_PERIOD_WIDTH = clks_alot_p::HALF_PERIOD_WIDTH,
   parameter int DRIFT_WIDTH       = clks_alot_p::DRIFT_COUNTER_WIDTH
) (
   input  common_p::clk_dom_s             sys_dom_i,
   input  logic                           applicator_en_i,
   input  logic [HALF_PERIOD_WIDTH-1:0]   high_len_i,
   input  logic [HALF_PERIOD_WIDTH-1:0]   low_len_i,
   input  logic                           pos_drift_ready_i,
   input  logic                           neg_drift_ready_i,
   output logic                           drift_accepted_o,
   output logic                           drift_conflict_o,
   output logic                           gen_clk_o,
   output logic                           rise_o,
   output logic                           fall_o,
   output logic signed [DRIFT_WIDTH-1:0]  net_drift_o
);
   import clks_alot_p::*;

   localparam int          CW      = HALF_PERIOD_WIDTH + 1;
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_TWO = {{(CW-2){1'b0}}, 2'b10};

   logic clk;
   logic rst;
   assign clk = sys_dom_i.clk;
   assign rst = sys_dom_i.sync_rst;

   applicator_state_e state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              gen_clk_q, gen_clk_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              acc_q, acc_d;
   logic              conflict_q, conflict_d;

   logic          pos_eff, neg_eff;
   logic          at_sample;
   logic [CW-1:0] base_len;
   logic [CW-1:0] next_len;
   logic          want_inc, want_dec, want_conflict;
   logic          net_inc, net_dec;

   // Requests are locked out while an acceptance is visible, so a producer that
   // drops ready in the accepted cycle can never be applied twice on an L=1 phase.
   assign pos_eff = pos_drift_ready_i && !acc_q;
   assign neg_eff = neg_drift_ready_i && !acc_q;

   assign at_sample = (state_q == IDLE) || (cnt_q == CNT_ONE);

   always_comb begin
      base_len = (state_q == HIGH) ? {1'b0, low_len_i} : {1'b0, high_len_i};
      if (base_len == '0) begin
         base_len = CNT_ONE;
      end

      next_len      = base_len;
      want_inc      = 1'b0;
      want_dec      = 1'b0;
      want_conflict = 1'b0;
      if (pos_eff && neg_eff) begin
         want_conflict = 1'b1;
      end else if (pos_eff) begin
         next_len = base_len + CNT_ONE;
         want_inc = 1'b1;
      end else if (neg_eff && (base_len >= CNT_TWO)) begin
         next_len = base_len - CNT_ONE;
         want_dec = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gen_clk_d  = gen_clk_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      acc_d      = 1'b0;
      conflict_d = 1'b0;
      net_inc    = 1'b0;
      net_dec    = 1'b0;

      if (!applicator_en_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         gen_clk_d = 1'b0;
      end else if (at_sample) begin
         state_d    = (state_q == HIGH) ? LOW : HIGH;
         cnt_d      = next_len;
         gen_clk_d  = (state_q != HIGH);
         rise_d     = (state_q != HIGH);
         fall_d     = (state_q == HIGH);
         acc_d      = want_inc || want_dec;
         conflict_d = want_conflict;
         net_inc    = want_inc;
         net_dec    = want_dec;
      end else begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gen_clk_q  <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         acc_q      <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gen_clk_q  <= gen_clk_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         acc_q      <= acc_d;
         conflict_q <= conflict_d;
      end
   end

   sat_signed_counter #(
      .W (DRIFT_WIDTH)
   ) u_net_drift (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (net_inc),
      .dec_i   (net_dec),
      .count_o (net_drift_o)
   );

   assign drift_accepted_o = acc_q;
   assign drift_conflict_o = conflict_q;
   assign gen_clk_o        = gen_clk_q;
   assign rise_o           = rise_q;
   assign fall_o           = fall_q;
endmodule

// File: tb/tb_drift_applicator.sv
// Directed bench for drift_applicator: phase timing, drift application, conflicts, saturation, enable/reset.
module tb_drift_applicator;
   import common_p::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clk_dom_s          dom;
   logic              en;
   logic [15:0]       hi, lo;
   logic              pos, neg;
   logic              acc, conf, gen, rise, fall;
   logic signed [3:0] net;

   int tests = 0;
   int fails = 0;

   assign dom.clk      = clk;
   assign dom.sync_rst = rst;

   drift_applicator #(
      .HALF_PERIOD_WIDTH (16),
      .DRIFT_WIDTH       (4)
   ) dut (
      .sys_dom_i         (dom),
      .applicator_en_i   (en),
      .high_len_i        (hi),
      .low_len_i         (lo),
      .pos_drift_ready_i (pos),
      .neg_drift_ready_i (neg),
      .drift_accepted_o  (acc),
      .drift_conflict_o  (conf),
      .gen_clk_o         (gen),
      .rise_o            (rise),
      .fall_o            (fall),
      .net_drift_o       (net)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT just out of reset in IDLE; the next tick is the first HIGH cycle (k=1).
   task automatic do_reset(input logic [15:0] h, input logic [15:0] l);
      rst = 1'b1; en = 1'b1; hi = h; lo = l; pos = 1'b0; neg = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; hi = 16'd3; lo = 16'd2; pos = 1'b0; neg = 1'b0;
      tick();
      tick();
      tests++;
      if ({gen, rise, fall, acc, conf} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_flags got %b want 00000", {gen, rise, fall, acc, conf});
      end
      tests++;
      if (net !== 4'sd0) begin
         fails++;
         $display("FAIL reset_net got %0d want 0", net);
      end
   endtask

   task automatic test_free_run();
      logic [4:0] exp;
      do_reset(16'd3, 16'd2);
      tests++;
      if (gen !== 1'b0) begin
         fails++;
         $display("FAIL idle_gen got %b want 0", gen);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         exp = {((k % 5) >= 1 && (k % 5) <= 3), (k % 5) == 1, (k % 5) == 4, 1'b0, 1'b0};
         tests++;
         if ({gen, rise, fall, acc, conf} !== exp || net !== 4'sd0) begin
            fails++;
            $display("FAIL free_run k=%0d got %b net %0d want %b net 0", k, {gen, rise, fall, acc, conf}, net, exp);
         end
      end
   endtask

   task automatic test_pos_drift();
      do_reset(16'd3, 16'd2);
      tick(); tick();
      pos = 1'b1;
      tick();
      tick();                                   // k4: first LOW cycle, lengthened
      tests++;
      if ({gen, fall, acc} !== 3'b011 || net !== 4'sd1) begin
         fails++;
         $display("FAIL pos_accept got gen/fall/acc %b net %0d want 011 net 1", {gen, fall, acc}, net);
      end
      tick();                                   // k5: request was held one extra cycle
      pos = 1'b0;
      tests++;
      if ({gen, acc} !== 2'b00) begin
         fails++;
         $display("FAIL pos_k5 got %b want 00", {gen, acc});
      end
      tick();
      tests++;
      if ({gen, acc} !== 2'b00) begin
         fails++;
         $display("FAIL pos_low3 got %b want 00", {gen, acc});
      end
      tick();                                   // k7: HIGH again
      tests++;
      if ({gen, rise, acc} !== 3'b110 || net !== 4'sd1) begin
         fails++;
         $display("FAIL pos_k7 got %b net %0d want 110 net 1", {gen, rise, acc}, net);
      end
      tick(); tick(); tick();                   // k10: unadjusted LOW
      tests++;
      if ({gen, fall, acc} !== 3'b010) begin
         fails++;
         $display("FAIL pos_k10 got %b want 010", {gen, fall, acc});
      end
      tick(); tick();                           // k12
      tests++;
      if ({gen, rise, acc} !== 3'b110 || net !== 4'sd1) begin
         fails++;
         $display("FAIL pos_k12 got %b net %0d want 110 net 1", {gen, rise, acc}, net);
      end
   endtask

   task automatic test_neg_pending();
      logic [1:0] exp_ga [2:5];
      exp_ga[2] = 2'b00; exp_ga[3] = 2'b10; exp_ga[4] = 2'b00; exp_ga[5] = 2'b10;
      do_reset(16'd1, 16'd1);
      tick();
      tests++;
      if ({gen, rise} !== 2'b11) begin
         fails++;
         $display("FAIL neg_k1 got %b want 11", {gen, rise});
      end
      neg = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         tick();
         if (k == 4) lo = 16'd4;
         tests++;
         if ({gen, acc} !== exp_ga[k]) begin
            fails++;
            $display("FAIL neg_pending k=%0d got %b want %b", k, {gen, acc}, exp_ga[k]);
         end
      end
      tick();                                   // k6: LOW shortened 4 -> 3
      neg = 1'b0;
      tests++;
      if ({gen, fall, acc} !== 3'b011 || net !== -4'sd1) begin
         fails++;
         $display("FAIL neg_accept got %b net %0d want 011 net -1", {gen, fall, acc}, net);
      end
      tick(); tick();
      tests++;
      if ({gen, acc} !== 2'b00) begin
         fails++;
         $display("FAIL neg_k8 got %b want 00", {gen, acc});
      end
      tick();
      tests++;
      if ({gen, rise, acc} !== 3'b110 || net !== -4'sd1) begin
         fails++;
         $display("FAIL neg_k9 got %b net %0d want 110 net -1", {gen, rise, acc}, net);
      end
   endtask

   task automatic test_conflict();
      logic [2:0] exp;
      do_reset(16'd3, 16'd2);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            pos = 1'b1;
            neg = 1'b1;
         end
         exp = {(k == 1 || k == 2 || k == 3 || k == 6 || k == 7 || k == 8),
                (k == 4 || k == 6 || k == 9), 1'b0};
         tests++;
         if ({gen, conf, acc} !== exp || net !== 4'sd0) begin
            fails++;
            $display("FAIL conflict k=%0d got %b net %0d want %b net 0", k, {gen, conf, acc}, net, exp);
         end
      end
      pos = 1'b0;
      neg = 1'b0;
   endtask

   task automatic test_saturation();
      int n;
      int e;
      logic [3:0] exp;
      do_reset(16'd1, 16'd1);
      tick();
      pos = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!acc && n < 10);
         e = (i > 7) ? 7 : i;
         exp = 4'(e);
         tests++;
         if (!acc || net !== exp) begin
            fails++;
            $display("FAIL sat_pos i=%0d acc %b net %0d want acc 1 net %0d", i, acc, net, e);
         end
      end
      pos = 1'b0; neg = 1'b1; hi = 16'd3; lo = 16'd3;
      for (int i = 1; i <= 15; i++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!acc && n < 10);
         e = 7 - i;
         if (e < -8) e = -8;
         exp = 4'(e);
         tests++;
         if (!acc || net !== exp) begin
            fails++;
            $display("FAIL sat_neg i=%0d acc %b net %0d want acc 1 net %0d", i, acc, net, e);
         end
      end
      neg = 1'b0;
   endtask

   task automatic test_enable_drop();
      do_reset(16'd3, 16'd2);
      tick(); tick();
      pos = 1'b1;
      tick(); tick();                           // k4: accepted, net=1
      tick();                                   // k5
      pos = 1'b0;
      tick(); tick();                           // k7: HIGH
      pos = 1'b1;
      tick();                                   // k8: mid-HIGH, drop enable with request pending
      en = 1'b0;
      tick();                                   // k9
      tests++;
      if ({gen, rise, fall, acc} !== 4'b0000 || net !== 4'sd1) begin
         fails++;
         $display("FAIL en_drop_k9 got %b net %0d want 0000 net 1", {gen, rise, fall, acc}, net);
      end
      tick();                                   // k10
      tests++;
      if ({gen, acc} !== 2'b00 || net !== 4'sd1) begin
         fails++;
         $display("FAIL en_drop_k10 got %b net %0d want 00 net 1", {gen, acc}, net);
      end
      rst = 1'b1;
      tick();                                   // k11
      tests++;
      if (net !== 4'sd0 || gen !== 1'b0) begin
         fails++;
         $display("FAIL en_drop_reset got net %0d gen %b want net 0 gen 0", net, gen);
      end
      rst = 1'b0; pos = 1'b0; en = 1'b1;
      tick();                                   // k12: restart
      tests++;
      if ({gen, rise, acc} !== 3'b110 || net !== 4'sd0) begin
         fails++;
         $display("FAIL en_restart got %b net %0d want 110 net 0", {gen, rise, acc}, net);
      end
   endtask

   initial begin
      en = 1'b0; hi = 16'd3; lo = 16'd2; pos = 1'b0; neg = 1'b0;
      test_reset();
      test_free_run();
      test_pos_drift();
      test_neg_pending();
      test_conflict();
      test_saturation();
      test_enable_drop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout after %0d tests, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end
endmodule
